// File: rtl/upack_channel_sequencer.sv
// Tags a serial sample stream with the next enabled channel index and frames it with sof/eof.
// Mask changes only take effect at frame boundaries. Define UPACK_SEQ_FRAME_CNT_EN to count completed frames.
module upack_channel_sequencer #(
    parameter  int NUM_CHANNELS = 4,
    parameter  int SAMPLE_WIDTH = 16,
    localparam int CW           = $clog2(NUM_CHANNELS)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    enable,
    input  logic [NUM_CHANNELS-1:0] chan_mask,
    input  logic [SAMPLE_WIDTH-1:0] s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [SAMPLE_WIDTH-1:0] m_data,
    output logic [CW-1:0]           m_chan,
    output logic                    m_sof,
    output logic                    m_eof,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    busy,
    output logic                    mask_err,
    output logic [31:0]             frame_count
);

    typedef enum logic [1:0] {IDLE, ARM, RUN, STOP} state_t;

    state_t                  state, state_nx;
    logic [NUM_CHANNELS-1:0] active_mask, mask_nx;
    logic [CW-1:0]           ptr, ptr_nx;
    logic                    err_nx;
    logic                    accept;
    logic                    cur_sof;
    logic                    cur_eof;

    function automatic logic [CW-1:0] lowest_bit(input logic [NUM_CHANNELS-1:0] m);
        lowest_bit = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--)
            if (m[i]) lowest_bit = CW'(i);
    endfunction

    function automatic logic [CW-1:0] highest_bit(input logic [NUM_CHANNELS-1:0] m);
        highest_bit = '0;
        for (int i = 0; i < NUM_CHANNELS; i++)
            if (m[i]) highest_bit = CW'(i);
    endfunction

    // Descending scan leaves the smallest set bit above p; none found means wrap to the lowest.
    function automatic logic [CW-1:0] next_bit(input logic [NUM_CHANNELS-1:0] m,
                                               input logic [CW-1:0] p);
        next_bit = lowest_bit(m);
        for (int i = NUM_CHANNELS - 1; i >= 0; i--)
            if (m[i] && (i > int'(p))) next_bit = CW'(i);
    endfunction

    assign s_ready = (state == RUN) && (!m_valid || m_ready);
    assign accept  = s_valid && s_ready;
    assign cur_sof = (ptr == lowest_bit(active_mask));
    assign cur_eof = (ptr == highest_bit(active_mask));
    assign busy    = (state != IDLE);

    always_comb begin
        state_nx = state;
        mask_nx  = active_mask;
        ptr_nx   = ptr;
        err_nx   = mask_err;
        case (state)
            IDLE: begin
                if (enable) begin
                    if (chan_mask != '0) state_nx = ARM;
                    else                 err_nx   = 1'b1;
                end
            end
            ARM: begin
                if (chan_mask != '0) begin
                    mask_nx  = chan_mask;
                    ptr_nx   = lowest_bit(chan_mask);
                    state_nx = RUN;
                end else begin
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end
            end
            RUN: begin
                // Frame boundary: stop, or relatch the mask with no bubble.
                if (accept) begin
                    if (cur_eof) begin
                        if (!enable) begin
                            state_nx = STOP;
                        end else if (chan_mask == '0) begin
                            err_nx   = 1'b1;
                            state_nx = STOP;
                        end else begin
                            mask_nx = chan_mask;
                            ptr_nx  = lowest_bit(chan_mask);
                        end
                    end else begin
                        ptr_nx = next_bit(active_mask, ptr);
                    end
                end
            end
            STOP: begin
                if (!m_valid || m_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            active_mask <= '0;
            ptr         <= '0;
            mask_err    <= 1'b0;
        end else begin
            state       <= state_nx;
            active_mask <= mask_nx;
            ptr         <= ptr_nx;
            mask_err    <= err_nx;
        end
    end

    // Output register: a new sample may load in the same cycle the old one is consumed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_data  <= '0;
            m_chan  <= '0;
            m_sof   <= 1'b0;
            m_eof   <= 1'b0;
            m_valid <= 1'b0;
        end else if (accept) begin
            m_data  <= s_data;
            m_chan  <= ptr;
            m_sof   <= cur_sof;
            m_eof   <= cur_eof;
            m_valid <= 1'b1;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

`ifdef UPACK_SEQ_FRAME_CNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                          frame_count <= '0;
        else if (m_valid && m_ready && m_eof) frame_count <= frame_count + 32'd1;
    end
`else
    assign frame_count = '0;
`endif

endmodule
